// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - two-stage RISC-V immediate generator with valid/ready handshake
module imm_gen_pipe #(
  parameter int XLEN     = 64,
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal,
  output logic [15:0]     illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  logic            s1_valid_q, s1_valid_d;
  logic [31:7]     s1_instr_q, s1_instr_d;
  fmt_e            s1_fmt_q, s1_fmt_d;
  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] imm_q, imm_d;
  fmt_e            fmt_q, fmt_d;
  logic            illegal_q, illegal_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            s1_ready, s2_ready;
  fmt_e            fmt_dec;
  logic            ext_bit;
  logic [63:0]     imm64;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;

  always_comb begin
    fmt_dec = FMT_NONE;
    unique case (instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: fmt_dec = FMT_I;
      7'b0100011:                         fmt_dec = FMT_S;
      7'b1100011:                         fmt_dec = FMT_B;
      7'b0110111, 7'b0010111:             fmt_dec = FMT_U;
      7'b1101111:                         fmt_dec = FMT_J;
      default:                            fmt_dec = FMT_NONE;
    endcase
  end

  // Opcode bits are not kept past S1: the decoded format carries everything S2 needs.
  assign ext_bit = SIGN_EXT && s1_instr_q[31];

  always_comb begin
    imm64 = 64'd0;
    unique case (s1_fmt_q)
      FMT_I: imm64 = {{52{ext_bit}}, s1_instr_q[31:20]};
      FMT_S: imm64 = {{52{ext_bit}}, s1_instr_q[31:25], s1_instr_q[11:7]};
      FMT_B: imm64 = {{51{ext_bit}}, s1_instr_q[31], s1_instr_q[7],
                      s1_instr_q[30:25], s1_instr_q[11:8], 1'b0};
      FMT_U: imm64 = {{32{ext_bit}}, s1_instr_q[31:12], 12'd0};
      FMT_J: imm64 = {{43{ext_bit}}, s1_instr_q[31], s1_instr_q[19:12],
                      s1_instr_q[20], s1_instr_q[30:21], 1'b0};
      default: imm64 = 64'd0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s1_fmt_d   = s1_fmt_q;
    s2_valid_d = s2_valid_q;
    imm_d      = imm_q;
    fmt_d      = fmt_q;
    illegal_d  = illegal_q;
    cnt_d      = cnt_q;

    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_instr_d = instr[31:7];
        s1_fmt_d   = fmt_dec;
      end
    end

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        imm_d     = imm64[XLEN-1:0];
        fmt_d     = s1_fmt_q;
        illegal_d = (s1_fmt_q == FMT_NONE);
      end
    end

    if (s2_valid_q && out_ready && illegal_q && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_fmt_q   <= FMT_NONE;
      s2_valid_q <= 1'b0;
      imm_q      <= '0;
      fmt_q      <= FMT_NONE;
      illegal_q  <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s1_fmt_q   <= s1_fmt_d;
      s2_valid_q <= s2_valid_d;
      imm_q      <= imm_d;
      fmt_q      <= fmt_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign imm         = imm_q;
  assign fmt         = fmt_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe (64-bit, zero-extend and 32-bit builds)
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] v64;
    logic [63:0] ze;
    logic [31:0] v32;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, illegal;
  logic [63:0] imm;
  logic [2:0]  fmt;
  logic [15:0] illegal_cnt;

  logic        in_ready_ze, out_valid_ze, illegal_ze;
  logic [63:0] imm_ze;
  logic [2:0]  fmt_ze;
  logic [15:0] cnt_ze;

  logic        in_ready_32, out_valid_32, illegal_32;
  logic [31:0] imm_32;
  logic [2:0]  fmt_32;
  logic [15:0] cnt_32;

  int          n_tests = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  exp_t        q[$];
  exp_t        pend;
  exp_t        e_mon;
  logic [15:0] mcnt = 16'd0;

  always #5 clk = ~clk;

  imm_gen_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .imm(imm), .fmt(fmt),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .SIGN_EXT(1'b0)) u_dut_ze (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ze), .instr(instr),
    .out_valid(out_valid_ze), .out_ready(out_ready), .imm(imm_ze), .fmt(fmt_ze),
    .illegal(illegal_ze), .illegal_cnt(cnt_ze)
  );

  imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1'b1)) u_dut_32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_32), .instr(instr),
    .out_valid(out_valid_32), .out_ready(out_ready), .imm(imm_32), .fmt(fmt_32),
    .illegal(illegal_32), .illegal_cnt(cnt_32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference immediates built with arithmetic shifts and masks rather than bit concatenation.
  function automatic exp_t mdl(input logic [31:0] w);
    exp_t   r;
    longint s, t;
    int     wid;
    s = $signed(w);
    r = '0;
    wid = 0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: begin r.fmt = 3'd1; r.v64 = s >>> 20; wid = 12; end
      7'h23: begin
        t = s >>> 25;
        r.fmt = 3'd2; r.v64 = (t << 5) | 64'(w[11:7]); wid = 12;
      end
      7'h63: begin
        t = s >>> 31;
        r.fmt = 3'd3;
        r.v64 = (t << 12) | (64'(w[7]) << 11) | (64'(w[30:25]) << 5) | (64'(w[11:8]) << 1);
        wid = 13;
      end
      7'h37, 7'h17: begin r.fmt = 3'd4; r.v64 = s & ~64'hFFF; wid = 32; end
      7'h6F: begin
        t = s >>> 31;
        r.fmt = 3'd5;
        r.v64 = (t << 20) | (64'(w[19:12]) << 12) | (64'(w[20]) << 11) | (64'(w[30:21]) << 1);
        wid = 21;
      end
      default: begin r.fmt = 3'd0; r.ill = 1'b1; r.v64 = 64'd0; end
    endcase
    r.ze  = (wid == 0) ? 64'd0 : (r.v64 & ((64'd1 << wid) - 64'd1));
    r.v32 = r.v64[31:0];
    return r;
  endfunction

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge with in_valid still high.
  task automatic send(input logic [31:0] w, input exp_t e);
    int n;
    in_valid = 1'b1;
    instr    = w;
    pend     = e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && out_ready) begin
          chk("sb_nonempty", q.size() != 0, 1);
          if (q.size() != 0) begin
            e_mon = q.pop_front();
            chk("imm", imm, e_mon.v64);
            chk("fmt", fmt, e_mon.fmt);
            chk("illegal", illegal, e_mon.ill);
            chk("ov_ze", out_valid_ze, 1);
            chk("imm_ze", imm_ze, e_mon.ze);
            chk("fmt_ze", fmt_ze, e_mon.fmt);
            chk("ov_32", out_valid_32, 1);
            chk("imm_32", imm_32, e_mon.v32);
            chk("ill_32", illegal_32, e_mon.ill);
            chk("illegal_cnt", illegal_cnt, mcnt);
            if (e_mon.ill && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(pend);
          acc_cnt++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] tv_w   [7];
    logic [63:0] tv_64  [7];
    logic [63:0] tv_ze  [7];
    logic [31:0] tv_32  [7];
    logic [2:0]  tv_fmt [7];
    logic [6:0]  ops    [9];
    exp_t        e;
    logic [63:0] imm_hold;
    logic [31:0] w;
    int          base;
    bit          rnd_done;

    tv_w = '{32'hFFF00093, 32'hFE000EE3, 32'h0080006F, 32'h12345037,
             32'h80000037, 32'h0000007F, 32'hFE112E23};
    tv_64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h8, 64'h12345000,
              64'hFFFFFFFF80000000, 64'h0, 64'hFFFFFFFFFFFFFFFC};
    tv_ze = '{64'hFFF, 64'h1FFC, 64'h8, 64'h12345000, 64'h80000000, 64'h0, 64'hFFC};
    tv_32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h8, 32'h12345000, 32'h80000000, 32'h0, 32'hFFFFFFFC};
    tv_fmt = '{3'd1, 3'd3, 3'd5, 3'd4, 3'd4, 3'd0, 3'd2};
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_imm", imm, 0);
    chk("rst_fmt", fmt, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_cnt", illegal_cnt, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed vectors; the first one also pins down the two-cycle latency.
    for (int i = 0; i < 7; i++) begin
      e.v64 = tv_64[i];
      e.ze  = tv_ze[i];
      e.v32 = tv_32[i];
      e.fmt = tv_fmt[i];
      e.ill = (tv_fmt[i] == 3'd0);
      send(tv_w[i], e);
      if (i == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2", out_valid, 1);
        @(posedge clk);
        #1;
      end
    end
    drain();
    @(negedge clk);
    chk("cnt_after_one", illegal_cnt, 1);
    @(posedge clk);
    #1;

    // Backpressure: two accepted, third held off with stable outputs.
    out_ready = 1'b0;
    base = acc_cnt;
    send(32'h00A00513, mdl(32'h00A00513));
    send(32'hFFC10113, mdl(32'hFFC10113));
    in_valid = 1'b1;
    instr    = 32'h7FF0006F;
    pend     = mdl(32'h7FF0006F);
    @(negedge clk);
    imm_hold = imm;
    chk("bp_front_imm", imm, q[0].v64);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_imm_stable", imm, imm_hold);
    end
    chk("bp_accepted", acc_cnt - base, 2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h7FF0006F, mdl(32'h7FF0006F));
    drain();
    chk("bp_total", acc_cnt - base, 3);
    @(posedge clk);
    #1;

    // Random traffic with random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          w = $urandom;
          w[6:0] = (($urandom_range(0, 9)) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
          send(w, mdl(w));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    @(posedge clk);
    #1;

    // Saturation of the illegal counter.
    for (int i = 0; i < 65540; i++) send(32'h0000007F, mdl(32'h0000007F));
    drain();
    @(negedge clk);
    chk("cnt_saturated", illegal_cnt, 16'hFFFF);
    @(posedge clk);
    #1;

    // Reset mid-stream with both stages full.
    out_ready = 1'b0;
    send(32'h00100093, mdl(32'h00100093));
    send(32'h00200113, mdl(32'h00200113));
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_cnt", illegal_cnt, 0);
    chk("mid_rst_imm", imm, 0);
    chk("mid_rst_illegal", illegal, 0);
    chk("mid_rst_ov_32", out_valid_32, 0);
    chk("mid_rst_cnt_ze", cnt_ze, 0);
    q.delete();
    mcnt = 16'd0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_in_ready_ze", in_ready_ze, 1);
    chk("post_rst_in_ready_32", in_ready_32, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(32'h0000007F, mdl(32'h0000007F));
    send(32'h12345037, mdl(32'h12345037));
    drain();
    @(negedge clk);
    chk("post_rst_cnt", illegal_cnt, 1);
    chk("post_rst_cnt_32", cnt_32, 1);
    chk("post_rst_fmt_32", fmt_32, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning output immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter SIGN_EXT, default 1, meaning 1 = sign-extend from immediate MSB, 0 = zero-extend (legacy mode).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  instr is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts instr this cycle.
REQ-007 SHALL have port instr  input  32  RV instruction word.
REQ-008 SHALL have port out_valid  output  1  imm/fmt/illegal are valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts output this cycle.
REQ-010 SHALL have port imm  output  XLEN  extended immediate.
REQ-011 SHALL have port fmt  output  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-012 SHALL have port illegal  output  1  opcode not in the decode table.
REQ-013 SHALL have port illegal_cnt  output  16  saturating count of illegal instrs delivered.

Function
REQ-014 SHALL be a two-stage pipeline: S1 registers instr plus decoded fmt; S2 registers assembled imm, fmt, illegal.
REQ-015 SHALL transfer on a port only when valid and ready are both 1 in the same cycle.
REQ-016 SHALL produce out_valid 2 cycles after acceptance when out_ready is held 1 (latency 2, throughput 1/cycle).
REQ-017 SHALL drive stage-ready as !stage_valid || downstream_ready; in_ready = S1 ready; no combinational path from in_valid to in_ready.
REQ-018 SHALL hold imm, fmt, illegal stable while out_valid=1 and out_ready=0.
REQ-019 SHALL allow a stage to load and unload in the same cycle without bubble or loss.
REQ-020 SHALL decode opcode instr[6:0]: 0000011, 0010011, 1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; all others -> fmt 0, illegal 1, imm 0.
REQ-021 SHALL assemble I = instr[31:20]; S = {instr[31:25], instr[11:7]}; B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}; U = {instr[31:12], 12 zeros}; J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-022 SHALL extend the assembled field to XLEN, replicating instr[31] when SIGN_EXT=1 and zeros when SIGN_EXT=0, for every format.
REQ-023 SHALL, for XLEN=32 U-format, use the 32-bit field directly with no extension.
REQ-024 SHALL increment illegal_cnt by 1 on each output handshake with illegal=1, saturating at 0xFFFF.
REQ-025 SHALL never accept more than 2 instructions outstanding; outputs SHALL leave in acceptance order.

Reset
REQ-026 SHALL, while rst=1, clear both stage valids, out_valid=0, imm=0, fmt=0, illegal=0, illegal_cnt=0, independent of clk.
REQ-027 SHALL drop in-flight instructions on reset mid-operation; in_ready=1 from the first clock after rst deasserts.

Verification
REQ-028 SHALL check I: instr 0xFFF00093, out_ready=1 -> 2 cycles later imm 0xFFFFFFFFFFFFFFFF, fmt 1, illegal 0; with SIGN_EXT=0 -> imm 0x0000000000000FFF.
REQ-029 SHALL check B and J: 0xFE000EE3 -> imm 0xFFFFFFFFFFFFFFFC, fmt 3; 0x0080006F -> imm 0x0000000000000008, fmt 5.
REQ-030 SHALL check U: 0x12345037 -> imm 0x0000000012345000; 0x80000037 -> 0xFFFFFFFF80000000 (XLEN=64) and 0x80000000 (XLEN=32).
REQ-031 SHALL check backpressure: out_ready=0, offer 3 back-to-back instrs -> exactly 2 accepted, in_ready=0, outputs stable; out_ready=1 -> all 3 emerge in order, no duplicates.
REQ-032 SHALL check illegal: 0x0000007F -> fmt 0, imm 0, illegal 1, illegal_cnt 0->1; after 0x10000 illegal outputs illegal_cnt stays 0xFFFF.
REQ-033 SHALL check reset mid-stream: assert rst between clock edges with both stages full -> out_valid=0 and illegal_cnt=0 immediately; nothing stale emerges after release.
